decoder_scan_ctrl: RTL and testbench



---
 rtl/decoder_scan_ctrl_pkg.sv | 14 +
 rtl/decoder_scan_ctrl_dwell_counter.sv | 36 +++
 rtl/decoder_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller: FSM state and scan-mode encodings.
package decoder_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/decoder_scan_ctrl_dwell_counter.sv
// Loadable down-counter timing how long each channel stays enabled.
module decoder_scan_ctrl_dwell_counter #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero_c
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Load takes priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sequencer driving the select and enable of the 3-to-8 decoder: steps through
// channels with a programmable dwell and a one-cycle enable-low gap between them.
// Optional build macro SCAN_SKIP_EN adds a per-channel ch_mask to skip channels.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SKIP_EN
  input  logic [NUM_CH-1:0]  ch_mask,
`endif
  output logic [SEL_W-1:0]   sel_o,
  output logic               en_o,
  output logic               busy,
  output logic               done
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_load_val;
  logic [DWELL_W-1:0] start_dwell_m1;
  logic [NUM_CH-1:0]  start_mask, run_mask;
  logic               has_nxt;
  logic [SEL_W-1:0]   nxt_sel;

`ifdef SCAN_SKIP_EN
  logic [NUM_CH-1:0]  mask_q, mask_d;
  assign start_mask = ch_mask;
  assign run_mask   = mask_q;
`else
  assign start_mask = '1;
  assign run_mask   = '1;
`endif

  // Lowest enabled channel in a mask.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Dwell of zero behaves as one; the counter holds remaining cycles minus one.
  assign start_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Next enabled channel above the current select, if any.
  always_comb begin
    has_nxt = 1'b0;
    nxt_sel = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (run_mask[i] && (i > int'(sel_q))) begin
        has_nxt = 1'b1;
        nxt_sel = SEL_W'(i);
      end
    end
  end

  // Next-state and next-output logic; stop overrides everything.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    en_d         = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    mode_d       = mode_q;
    dwell_d      = dwell_q;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_q;
    cnt_dec      = 1'b0;
`ifdef SCAN_SKIP_EN
    mask_d       = mask_q;
`endif
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (|start_mask)) begin
            state_d      = ST_DWELL;
            mode_d       = mode;
            dwell_d      = start_dwell_m1;
            sel_d        = lowest_set(start_mask);
            cnt_load     = 1'b1;
            cnt_load_val = start_dwell_m1;
            en_d         = 1'b1;
            busy_d       = 1'b1;
`ifdef SCAN_SKIP_EN
            mask_d       = ch_mask;
`endif
          end
        end
        ST_DWELL: begin
          busy_d = 1'b1;
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
            en_d    = 1'b1;
          end else if (has_nxt) begin
            state_d = ST_GAP;
            sel_d   = nxt_sel;
          end else if (mode_q == MODE_CONT) begin
            state_d = ST_GAP;
            sel_d   = lowest_set(run_mask);
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        ST_GAP: begin
          state_d  = ST_DWELL;
          cnt_load = 1'b1;
          en_d     = 1'b1;
          busy_d   = 1'b1;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_SINGLE;
      dwell_q <= '0;
`ifdef SCAN_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
`ifdef SCAN_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  decoder_scan_ctrl_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero)
  );

  assign sel_o = sel_q;
  assign en_o  = en_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: expected per-cycle outputs are queued
// from closed-form scan timing and compared one cycle at a time.
module tb_decoder_scan_ctrl;
  import decoder_scan_ctrl_pkg::*;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned DWELL_W = 8;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             busy;
    logic             done;
  } obs_t;

  logic               clk = 1'b0;
  logic               rst, start, stop, mode;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   sel_o;
  logic               en_o, busy, done;
`ifdef SCAN_SKIP_EN
  logic [NUM_CH-1:0]  ch_mask;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  decoder_scan_ctrl #(
    .SEL_W   (SEL_W),
    .NUM_CH  (NUM_CH),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .dwell   (dwell),
`ifdef SCAN_SKIP_EN
    .ch_mask (ch_mask),
`endif
    .sel_o   (sel_o),
    .en_o    (en_o),
    .busy    (busy),
    .done    (done)
  );

  // Single comparison point; values are {sel,en,busy,done}.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sel,en,busy,done}=0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input int s, input bit e, input bit b, input bit d);
    obs_t o;
    o.sel  = SEL_W'(s);
    o.en   = e;
    o.busy = b;
    o.done = d;
    return o;
  endfunction

  // Queue the expected outputs for cycles 1..ncyc after a start at cycle 0.
  task automatic push_pass(input int d, input bit cont, input int ncyc);
    int de, per, k, r;
    de  = (d == 0) ? 1 : d;
    per = de + 1;
    for (int c = 1; c <= ncyc; c++) begin
      k = c / per;
      r = c % per;
      if (!cont && c == int'(NUM_CH) * per)      exp_q.push_back(mk(int'(NUM_CH) - 1, 0, 0, 1));
      else if (!cont && c > int'(NUM_CH) * per)  exp_q.push_back(mk(int'(NUM_CH) - 1, 0, 0, 0));
      else                                       exp_q.push_back(mk(k % int'(NUM_CH), r != 0, 1, 0));
    end
  endtask

  // Advance one clock and compare DUT outputs against the next queued entry.
  task automatic tick_check(input string tag);
    obs_t got, e;
    @(posedge clk);
    #1;
    got = {sel_o, en_o, busy, done};
    if (exp_q.size() == 0) e = '1;
    else                   e = exp_q.pop_front();
    check_eq(tag, 32'(got), 32'(e));
  endtask

  task automatic kick(input logic m, input int d);
    mode  = m;
    dwell = DWELL_W'(d);
    start = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = MODE_SINGLE; dwell = '0;
`ifdef SCAN_SKIP_EN
    ch_mask = '1;
`endif
    #1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0));
      tick_check($sformatf("reset_c%0d", i));
    end
    rst = 1'b0;

    // Single pass, dwell 2: done at cycle 24
    push_pass(2, 1'b0, 27);
    kick(MODE_SINGLE, 2);
    for (int c = 1; c <= 27; c++) begin
      tick_check($sformatf("single_d2_c%0d", c));
      start = 1'b0;
    end

    // Continuous, dwell 1: wraps 7->0 through a gap, never done; then stop
    push_pass(1, 1'b1, 40);
    kick(MODE_CONT, 1);
    for (int c = 1; c <= 40; c++) begin
      tick_check($sformatf("cont_d1_c%0d", c));
      start = 1'b0;
    end
    stop = 1'b1;
    exp_q.push_back(mk(4, 0, 0, 0));
    tick_check("cont_stop");
    stop = 1'b0;

    // Dwell 0 treated as 1: done at cycle 16
    push_pass(0, 1'b0, 18);
    kick(MODE_SINGLE, 0);
    for (int c = 1; c <= 18; c++) begin
      tick_check($sformatf("dwell0_c%0d", c));
      start = 1'b0;
    end

    // Stop during channel 3 dwell, with a simultaneous start
    push_pass(2, 1'b0, 10);
    kick(MODE_SINGLE, 2);
    for (int c = 1; c <= 10; c++) begin
      tick_check($sformatf("stop_pre_c%0d", c));
      start = 1'b0;
    end
    stop = 1'b1; start = 1'b1;
    exp_q.push_back(mk(3, 0, 0, 0));
    tick_check("stop_ch3");
    stop = 1'b0; start = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 0));
    tick_check("stop_hold");

    // Start pulses while busy/done and dwell/mode changes are ignored
    push_pass(3, 1'b0, 34);
    kick(MODE_SINGLE, 3);
    for (int c = 1; c <= 34; c++) begin
      tick_check($sformatf("nostart_c%0d", c));
      start = 1'b0;
      if (c == 5 || c == 12 || c == 20 || c == 31 || c == 32) begin
        start = 1'b1;
        dwell = DWELL_W'(1);
        mode  = MODE_CONT;
      end
    end
    start = 1'b0;

    // Reset mid-scan
    push_pass(1, 1'b0, 5);
    kick(MODE_SINGLE, 1);
    for (int c = 1; c <= 5; c++) begin
      tick_check($sformatf("rstmid_c%0d", c));
      start = 1'b0;
    end
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    tick_check("rstmid_rst");
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0));
    tick_check("rstmid_idle");

`ifdef SCAN_SKIP_EN
    // Masked scan of channels 2, 5, 7; done at cycle 6
    ch_mask = 8'b1010_0100;
    exp_q.push_back(mk(2, 1, 1, 0));
    exp_q.push_back(mk(5, 0, 1, 0));
    exp_q.push_back(mk(5, 1, 1, 0));
    exp_q.push_back(mk(7, 0, 1, 0));
    exp_q.push_back(mk(7, 1, 1, 0));
    exp_q.push_back(mk(7, 0, 0, 1));
    exp_q.push_back(mk(7, 0, 0, 0));
    kick(MODE_SINGLE, 1);
    for (int c = 1; c <= 7; c++) begin
      tick_check($sformatf("skip_c%0d", c));
      start = 1'b0;
    end
    // All-zero mask: start ignored
    ch_mask = '0;
    kick(MODE_SINGLE, 1);
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back(mk(7, 0, 0, 0));
      tick_check($sformatf("skip_zero_c%0d", c));
    end
    start = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
